// File: rtl/comma_word_aligner.sv
// comma_word_aligner: finds 10-bit symbol boundaries in the recovered serial stream using K28.5.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module comma_word_aligner #(
  parameter int SYM_WIDTH  = 10,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Bit,
  input  logic                 i_Bit_Valid,
  output logic [SYM_WIDTH-1:0] o_Sym,
  output logic                 o_Sym_Valid,
  output logic                 o_Is_Comma,
  output logic                 o_Locked,
  output logic                 o_Realign
);

  localparam logic [SYM_WIDTH-1:0] COMMA_NEG  = 10'b0011111010;
  localparam logic [SYM_WIDTH-1:0] COMMA_POS  = 10'b1100000101;
  localparam logic [3:0]           LAST_PHASE = 4'(SYM_WIDTH - 1);
  localparam logic [3:0]           LOCK_M1    = 4'(LOCK_COUNT - 1);
  localparam logic [3:0]           ERR_M1     = 4'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state;
  logic [SYM_WIDTH-1:0] win;
  logic [3:0]           phase;
  logic [3:0]           good_cnt;
  logic [3:0]           err_cnt;

  logic [SYM_WIDTH-1:0] next_win;
  logic                 is_comma;
  logic                 at_boundary;
  logic [3:0]           phase_inc;
  logic                 verify_done;
  logic                 emit;

  assign next_win    = {win[SYM_WIDTH-2:0], i_Bit};
  assign is_comma    = (next_win == COMMA_NEG) || (next_win == COMMA_POS);
  assign at_boundary = (phase == LAST_PHASE);
  assign phase_inc   = at_boundary ? 4'd0 : phase + 4'd1;
  assign verify_done = at_boundary && is_comma && (good_cnt >= LOCK_M1);

  // A symbol is emitted on every boundary whose successor state is LOCKED,
  // including the comma that completes lock (a HUNT comma when one suffices).
  assign emit = i_Bit_Valid &&
                (((state == LOCKED) && at_boundary) ||
                 ((state == VERIFY) && verify_done) ||
                 ((state == HUNT) && is_comma && (LOCK_COUNT == 1)));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= HUNT;
      win         <= '0;
      phase       <= '0;
      good_cnt    <= '0;
      err_cnt     <= '0;
      o_Sym       <= '0;
      o_Sym_Valid <= 1'b0;
      o_Is_Comma  <= 1'b0;
      o_Locked    <= 1'b0;
      o_Realign   <= 1'b0;
    end else begin
      o_Sym_Valid <= 1'b0;
      o_Realign   <= 1'b0;
      if (i_Bit_Valid) begin
        win <= next_win;
        if (emit) begin
          o_Sym       <= next_win;
          o_Sym_Valid <= 1'b1;
          o_Is_Comma  <= is_comma;
        end
        case (state)
          HUNT: begin
            if (is_comma) begin
              phase     <= '0;
              good_cnt  <= 4'd1;
              o_Realign <= 1'b1;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                o_Locked <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (at_boundary) begin
              phase <= '0;
              if (is_comma) begin
                good_cnt <= good_cnt + 4'd1;
                if (verify_done) begin
                  state    <= LOCKED;
                  o_Locked <= 1'b1;
                end
              end
            end else if (is_comma) begin
              phase     <= '0;
              good_cnt  <= 4'd1;
              o_Realign <= 1'b1;
            end else begin
              phase <= phase_inc;
            end
          end
          LOCKED: begin
            phase <= phase_inc;
            if (at_boundary) begin
              if (is_comma) err_cnt <= '0;
            end else if (is_comma) begin
              // Loss of lock is silent; the next comma seen in HUNT realigns.
              if (err_cnt >= ERR_M1) begin
                state    <= HUNT;
                o_Locked <= 1'b0;
                err_cnt  <= '0;
                good_cnt <= '0;
              end else begin
                err_cnt <= err_cnt + 4'd1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            o_Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/comma_word_aligner.md
Name: comma_word_aligner

Overview:
- Receive-side front end of the SerDes. Takes the recovered serial bit stream one bit per enabled clock and finds 10-bit symbol boundaries using the K28.5 comma.
- Outputs aligned 10-bit symbols with a valid strobe to the Deserializer write port, which does FIFO buffering and 8b/10b decode. The Serializer emits commas and this block consumes that stream.
- Runs entirely in the fast (bit-rate) clock domain.

Parameters:
- SYM_WIDTH, 10, symbol width in bits. Fixed for 8b/10b; any other value is unsupported.
- LOCK_COUNT, 3, consecutive boundary-aligned commas needed to declare lock (range 1..15).
- ERR_LIMIT, 4, consecutive misaligned commas while locked that force loss of lock (range 1..15).

Ports:
- i_Clk, input, 1, fast bit clock. All logic is on the rising edge.
- i_Rst_n, input, 1, asynchronous active-low reset. Assertion is asynchronous; release is synchronous to i_Clk.
- i_Bit, input, 1, serial data bit. Transmission order is bit a first.
- i_Bit_Valid, input, 1, qualifies i_Bit. When low, no state changes.
- o_Sym, output, SYM_WIDTH, aligned symbol. Bit [9] is the first-received bit (a), bit [0] is j.
- o_Sym_Valid, output, 1, one-cycle strobe for o_Sym.
- o_Is_Comma, output, 1, o_Sym is K28.5. Qualified by o_Sym_Valid.
- o_Locked, output, 1, alignment locked.
- o_Realign, output, 1, one-cycle pulse when the boundary is moved.

Behaviour:
- Reset: state HUNT; window, phase, good count and error count = 0; o_Sym = 0; o_Sym_Valid, o_Is_Comma, o_Locked, o_Realign = 0.
- Reset mid-operation: drops lock and clears all state immediately (asynchronously).
- Accepted bit: a cycle with i_Bit_Valid = 1. For every accepted bit, w_Next = {r_Win[8:0], i_Bit} and r_Win <= w_Next.
- Comma: w_Next equals 10'b0011111010 (RD-) or 10'b1100000101 (RD+).
- Boundary: an accepted bit while r_Phase == 9. In VERIFY and LOCKED, r_Phase increments per accepted bit and wraps 9 -> 0.
- HUNT:
  - r_Phase is ignored.
  - Comma on any accepted bit -> r_Phase <= 0, good count <= 1, pulse o_Realign, go to VERIFY.
  - If LOCK_COUNT == 1, go directly to LOCKED instead.
- VERIFY:
  - Boundary with comma -> good count + 1. Reaching LOCK_COUNT -> LOCKED.
  - Boundary without comma -> no change.
  - Comma at a non-boundary -> realign: r_Phase <= 0, good count <= 1, pulse o_Realign, stay in VERIFY.
- LOCKED:
  - Boundary with comma -> error count <= 0.
  - Comma at a non-boundary -> error count + 1. Reaching ERR_LIMIT -> HUNT, error count <= 0, good count <= 0. o_Realign is not pulsed.
  - Non-comma symbols never change either counter.
- Outputs, all registered, 1-cycle latency:
  - At a boundary where next state is LOCKED (including the boundary that completes lock): o_Sym <= w_Next, o_Sym_Valid <= 1, o_Is_Comma <= comma.
  - o_Sym holds its value between strobes.
  - o_Locked = (state == LOCKED), registered.
- Cycles with i_Bit_Valid = 0: no shift, no phase advance; pulses deassert; o_Sym is held.
- Simultaneous boundary and comma is a good comma, not a misaligned one.
- Counters saturate at their limits and never wrap.
- No decode, disparity or code-violation checking in this block; those belong to the Deserializer.

Test Plan:
- Reset: hold i_Rst_n = 0 with bits toggling -> all outputs 0. Assert i_Rst_n mid-lock -> o_Locked falls without waiting for a clock edge.
- Lock: bits 101, then K28.5- 0011111010, K28.5+ 1100000101, K28.5- 0011111010, all valid every cycle -> o_Realign pulses the cycle after accepted bit 13. o_Locked rises, and o_Sym_Valid = 1 with o_Sym = 0011111010 and o_Is_Comma = 1, the cycle after bit 33.
- Data after lock: D21.5 1010101010 x4 -> four strobes 10 accepted bits apart, o_Sym = 1010101010, o_Is_Comma = 0, o_Locked stays 1.
- Slip tolerance: while locked, insert one extra bit before a comma, then resume on the shifted alignment. First misaligned comma -> error count 1, still locked. Four misaligned commas -> o_Locked = 0. Continuing commas -> relock after 3 commas on the new phase.
- Realign in VERIFY: after the first comma, inject a comma 4 bits early -> o_Realign pulses and lock occurs 3 commas after the new position.
- Valid gaps: during lock, drive i_Bit_Valid = 0 for 7 random cycles per symbol -> identical o_Sym sequence, with strobe spacing equal to 10 accepted bits.
